aes_inv_cipher_iter: RTL and testbench
======================================

// Module: aes_inv_cipher_iter
// PURPOSE
//  Iterative AES inverse cipher (decryption) core; one round per clock.
//  Per round: InvShiftRows, InvSubBytes, round-key XOR, InvMixColumns.
//  Round keys come from an external key store through an index/data lookup port.
//  Sits between the ciphertext source (valid/ready) and the plaintext sink (valid/ready).
// PARAMETERS
//  NR         10   number of rounds; 10 = AES-128; 12 and 14 also legal
//  KIDX_W     4    width of rk_idx; must satisfy 2**KIDX_W > NR
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        ciphertext block valid
//  in_ready   out  1        core can accept a block
//  in_data    in   128      ciphertext block
//  rk_idx     out  KIDX_W   index of the round key needed this cycle
//  rk_data    in   128      round key[rk_idx]; combinational and valid in the same cycle
//  out_valid  out  1        plaintext valid
//  out_ready  in   1        sink accepts plaintext
//  out_data   out  128      plaintext block
//  busy       out  1        high in ROUND and FINAL states
// BEHAVIOUR
//  Byte order (data and keys): bits[127:120] = byte 0. Bytes are column-major per FIPS-197.
//    Bytes 0-3 = column 0, row = byte index mod 4.
//  FSM states: IDLE, ROUND, FINAL, DONE. Registers: st[127:0], rnd[KIDX_W-1:0].
//  IDLE:
//    - in_ready = 1, rk_idx = NR.
//    - On in_valid: st <= in_data ^ rk_data, rnd <= NR-1, go to ROUND.
//  ROUND:
//    - rk_idx = rnd.
//    - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_data).
//    - rnd decrements; when rnd == 1, go to FINAL with rnd <= 0.
//  FINAL:
//    - rk_idx = 0.
//    - st <= InvSubBytes(InvShiftRows(st)) ^ rk_data; go to DONE.
//  DONE:
//    - out_valid = 1, out_data = st.
//    - out_data and out_valid hold stable until out_ready.
//    - On out_ready: go to IDLE.
//  Latency: the accept edge is followed by NR further edges.
//    out_valid is high in the cycle after the NR-th edge.
//  Throughput: one block per NR+2 cycles (one per NR+1 with the macro below).
//  in_ready = 0 outside IDLE; in_valid there is ignored and in_data is not sampled.
//  rk_idx is a registered-state decode only; it never depends on in_valid or out_ready.
//  InvSubBytes: inverse affine transform, then GF(2^8) inverse modulo x^8+x^4+x^3+x+1.
//    Inverse of 0x00 = 0x00. Either a table or a composite-field implementation is acceptable.
//  InvMixColumns: matrix {0e,0b,0d,09} circulant over GF(2^8).
//  Reset, including mid-operation:
//    - FSM returns to IDLE; st=0, rnd=0; no output is produced for the aborted block.
//    - out_valid=0, out_data=0, busy=0; in_ready=1 and rk_idx=NR from the first cycle after reset.
// CONFIGURATION
//  AES_INV_B2B_EN defined:
//    - in DONE, in_ready = out_ready and rk_idx = NR.
//    - When out_valid&out_ready&in_valid: the core loads the new block as in IDLE and goes to ROUND.
//      No idle bubble between blocks.
//  AES_INV_B2B_EN undefined: in_ready = 0 in DONE; a new block is accepted no earlier than IDLE.
// TESTING
//  FIPS-197 App B vector:
//    - Stimulus: ct 3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c.
//    - Required response: out_data 3243f6a8885a308d313198a2e0370734, 10 edges after accept.
//  FIPS-197 C.1 vector:
//    - Stimulus: ct 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102..0f.
//    - Required response: out_data 00112233445566778899aabbccddeeff.
//    - rk_idx sequence 10,9,..,1,0.
//  Backpressure:
//    - Stimulus: hold out_ready=0 for 5 cycles in DONE; assert in_valid during ROUND.
//    - Required response: out_data stable; in_ready=0; no second block accepted.
//  Reset mid-operation:
//    - Stimulus: deassert rst_n at round 5.
//    - Required response: out_valid=0, in_ready=1, busy=0; the next block decrypts correctly.
//  AES_INV_B2B_EN:
//    - Stimulus: two blocks with in_valid and out_ready held high.
//    - Required response: second out_valid 11 cycles after the first.
//    - Without the macro: 12 cycles.

Source files
------------

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched via rk_idx/rk_data.
// Optional macro AES_INV_B2B_EN lets DONE hand off directly to the next block with no idle bubble.
module aes_inv_cipher_iter #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic [KIDX_W-1:0] rk_idx,
    input  logic [127:0]      rk_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

    localparam logic [KIDX_W-1:0] RK_LAST  = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] RND_INIT = KIDX_W'(NR - 1);
    localparam logic [KIDX_W-1:0] RND_ONE  = KIDX_W'(1);

    state_t              state_q;
    logic [127:0]        st_q;
    logic [KIDX_W-1:0]   rnd_q;

    logic [127:0]        sub_w;
    logic [127:0]        ark_w;
    logic [127:0]        mix_w;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse and maps 0 to 0 without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // InvShiftRows folded into the byte routing: row r of column c comes from column c-r
    for (genvar gi = 0; gi < 16; gi++) begin : g_sub
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
        assign sub_w[127-8*gi -: 8] = inv_sbox(st_q[127-8*SRC -: 8]);
    end

    assign ark_w = sub_w ^ rk_data;

    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark_w[127-32*gi -: 8];
        assign a1 = ark_w[119-32*gi -: 8];
        assign a2 = ark_w[111-32*gi -: 8];
        assign a3 = ark_w[103-32*gi -: 8];
        assign mix_w[127-32*gi -: 32] = {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
        };
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        st_q    <= in_data ^ rk_data;
                        rnd_q   <= RND_INIT;
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    st_q <= mix_w;
                    if (rnd_q == RND_ONE) begin
                        rnd_q   <= '0;
                        state_q <= S_FINAL;
                    end else begin
                        rnd_q <= rnd_q - RND_ONE;
                    end
                end
                S_FINAL: begin
                    st_q    <= ark_w;
                    state_q <= S_DONE;
                end
                S_DONE: begin
`ifdef AES_INV_B2B_EN
                    if (out_ready) begin
                        if (in_valid) begin
                            st_q    <= in_data ^ rk_data;
                            rnd_q   <= RND_INIT;
                            state_q <= S_ROUND;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
`else
                    if (out_ready) state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rk_idx   = RK_LAST;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_ROUND: rk_idx = rnd_q;
            S_FINAL: rk_idx = '0;
`ifdef AES_INV_B2B_EN
            S_DONE:  in_ready = out_ready;
`endif
            default: ;
        endcase
    end

    assign busy      = (state_q == S_ROUND) || (state_q == S_FINAL);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_valid ? st_q : '0;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 vectors, backpressure, mid-block reset, throughput.
module tb_aes_inv_cipher_iter;

    localparam int NR     = 10;
    localparam int KIDX_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [127:0]      in_data = '0;
    logic [KIDX_W-1:0] rk_idx;
    logic [127:0]      rk_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [127:0]      out_data;
    logic              busy;

    logic [127:0] rk_tbl [16];
    int n_checks = 0;
    int n_bad    = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    aes_inv_cipher_iter #(.NR(NR), .KIDX_W(KIDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign rk_data = rk_tbl[rk_idx];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // Forward S-box from first principles: brute-force inverse, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(a, 8'(y)) == 8'h01) b = 8'(y);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tbl[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // One block: checks rk_idx sequence, latency, result, optional stall in DONE and junk in_valid
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                             input int stall, input bit junk);
        int f;
        @(negedge clk);
        check_eq({tag, ".idle_in_ready"}, in_ready, 1);
        check_eq({tag, ".idle_rk_idx"}, rk_idx, NR);
        in_valid = 1'b1;
        in_data  = ct;
        @(posedge clk);
        @(negedge clk);
        in_valid = junk;
        in_data  = junk ? ~ct : '0;
        f = 0;
        while (!out_valid && f < 40) begin
            check_eq({tag, ".rk_idx"}, rk_idx, NR - 1 - f);
            check_eq({tag, ".busy"}, busy, 1);
            check_eq({tag, ".round_in_ready"}, in_ready, 0);
            @(posedge clk);
            f++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq({tag, ".latency"}, f, NR);
        check_eq({tag, ".out_data"}, out_data, pt);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, ".stall_valid"}, out_valid, 1);
            check_eq({tag, ".stall_data"}, out_data, pt);
            check_eq({tag, ".stall_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, ".after_valid"}, out_valid, 0);
        check_eq({tag, ".after_busy"}, busy, 0);
        check_eq({tag, ".after_in_ready"}, in_ready, 1);
        $display("block %s ct=%h pt=%h edges=%0d", tag, ct, out_data, f);
    endtask

    task automatic run_pair(input logic [127:0] ct, input logic [127:0] pt, input int gap);
        int n_acc;
        int n_out;
        int t_out [2];
        n_acc = 0;
        n_out = 0;
        t_out[0] = 0;
        t_out[1] = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = ct;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && n_out < 2; cyc++) begin
            if (n_acc == 2) in_valid = 1'b0;
            if (in_valid && in_ready) n_acc++;
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                check_eq("pair.out_data", out_data, pt);
                t_out[n_out] = cyc;
                n_out++;
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("pair.count", n_out, 2);
        check_eq("pair.gap", t_out[1] - t_out[0], gap);
        check_eq("pair.end_idle", in_ready, 1);
        $display("pair ct=%h outputs=%0d gap=%0d", ct, n_out, t_out[1] - t_out[0]);
    endtask

    initial begin
        load_key(KEY_B);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset.in_ready", in_ready, 1);
        check_eq("reset.rk_idx", rk_idx, NR);
        check_eq("reset.out_valid", out_valid, 0);
        check_eq("reset.busy", busy, 0);
        check_eq("reset.out_data", out_data, 0);

        run_block("appB", CT_B, PT_B, 0, 1'b0);

        load_key(KEY_C);
        run_block("c1_bp", CT_C, PT_C, 5, 1'b1);

        // Abort a block mid-way and confirm the next one is unaffected
        load_key(KEY_B);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = CT_B;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("abort.rk_idx_before", rk_idx, 5);
        rst_n = 1'b0;
        #1;
        check_eq("abort.out_valid", out_valid, 0);
        check_eq("abort.in_ready", in_ready, 1);
        check_eq("abort.busy", busy, 0);
        check_eq("abort.rk_idx", rk_idx, NR);
        check_eq("abort.out_data", out_data, 0);
        $display("reset asserted mid-block at round 5");
        @(negedge clk);
        rst_n = 1'b1;
        run_block("after_abort", CT_B, PT_B, 0, 1'b0);

`ifdef AES_INV_B2B_EN
        run_pair(CT_B, PT_B, NR + 1);
`else
        run_pair(CT_B, PT_B, NR + 2);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
